// File: rtl/fault_status_monitor.sv
// fault_status_monitor: qualifies fault sources against a persistence threshold,
// latches them as sticky bits with priority-encoded crash code, first-fault capture
// with timestamp, saturating per-source event counters and a four-phase clear.
//   clk, rst      clock, asynchronous active-high reset
//   fault_in      raw fault levels (bit0 highest priority, code = index+1)
//   fault_mask    1 = source ignored
//   clr_req       clear request (level), clr_ack acknowledge
//   cnt_sel       counter index, cnt_out its event count (registered)
//   sticky        latched faults; crash_code / crash decoded from sticky
//   first_code    code of first fault since reset/clear, first_ts its timestamp
//   irq           one-cycle pulse when any sticky bit rises
module fault_status_monitor #(
    parameter int unsigned NUM_SRC  = 4,
    parameter int unsigned CODE_W   = 3,
    parameter int unsigned QUAL_CYC = 4,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned TS_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_SRC-1:0]  fault_in,
    input  logic [NUM_SRC-1:0]  fault_mask,
    input  logic                clr_req,
    output logic                clr_ack,
    input  logic [CODE_W-1:0]   cnt_sel,
    output logic [CNT_W-1:0]    cnt_out,
    output logic [NUM_SRC-1:0]  sticky,
    output logic [CODE_W-1:0]   crash_code,
    output logic [CODE_W-1:0]   first_code,
    output logic [TS_W-1:0]     first_ts,
    output logic                crash,
    output logic                irq
);

    localparam int unsigned QW = $clog2(QUAL_CYC + 1);
    localparam logic [QW-1:0]    Q_MAX   = QW'(QUAL_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, CLEAR, ACK} state_e;

    state_e              state_q, state_d;
    logic                clr_ack_q, clr_ack_d;
    logic [TS_W-1:0]     ts_q;
    logic [QW-1:0]       q_cnt_q [NUM_SRC];
    logic [QW-1:0]       q_cnt_d [NUM_SRC];
    logic [NUM_SRC-1:0]  qual_c, qual_prev_q, ev_c;
    logic [NUM_SRC-1:0]  sticky_q, sticky_d, sticky_base;
    logic [CNT_W-1:0]    ev_cnt_q [NUM_SRC];
    logic [CNT_W-1:0]    ev_cnt_d [NUM_SRC];
    logic [CNT_W-1:0]    cnt_base [NUM_SRC];
    logic [CODE_W-1:0]   first_code_q, first_code_d, first_base, ev_code;
    logic [TS_W-1:0]     first_ts_q, first_ts_d;
    logic                irq_q, irq_d, wipe;
    logic [CNT_W-1:0]    cnt_out_q, cnt_out_d;

    // Clear handshake next-state
    always_comb begin
        state_d   = state_q;
        clr_ack_d = 1'b0;
        case (state_q)
            IDLE:    if (clr_req) state_d = CLEAR;
            CLEAR:   state_d = ACK;
            ACK:     if (!clr_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        clr_ack_d = (state_d == ACK);
    end

    // Qualification, events, sticky/counter/first-fault update
    always_comb begin
        wipe        = (state_q == CLEAR);
        sticky_base = wipe ? '0 : sticky_q;
        first_base  = wipe ? '0 : first_code_q;
        ev_code     = '0;
        cnt_out_d   = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            qual_c[i] = (q_cnt_q[i] == Q_MAX);
            if (fault_in[i] && !fault_mask[i])
                q_cnt_d[i] = qual_c[i] ? Q_MAX : q_cnt_q[i] + QW'(1);
            else
                q_cnt_d[i] = '0;
        end
        ev_c     = qual_c & ~qual_prev_q;
        sticky_d = sticky_base | ev_c;
        irq_d    = |(ev_c & ~sticky_base);
        // An event in the clear cycle is applied on top of the wiped state
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            cnt_base[i] = wipe ? '0 : ev_cnt_q[i];
            ev_cnt_d[i] = (ev_c[i] && cnt_base[i] != CNT_MAX) ? cnt_base[i] + CNT_W'(1)
                                                              : cnt_base[i];
            if (cnt_sel == CODE_W'(i)) cnt_out_d = ev_cnt_q[i];
        end
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (ev_c[i]) ev_code = CODE_W'(i + 1);
        end
        first_code_d = first_base;
        first_ts_d   = wipe ? '0 : first_ts_q;
        if (first_base == '0 && ev_c != '0) begin
            first_code_d = ev_code;
            first_ts_d   = ts_q;
        end
    end

    // Priority encoder: lowest set sticky index wins
    always_comb begin
        crash_code = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (sticky_q[i]) crash_code = CODE_W'(i + 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            clr_ack_q    <= 1'b0;
            ts_q         <= '0;
            qual_prev_q  <= '0;
            sticky_q     <= '0;
            first_code_q <= '0;
            first_ts_q   <= '0;
            irq_q        <= 1'b0;
            cnt_out_q    <= '0;
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                q_cnt_q[i]  <= '0;
                ev_cnt_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            clr_ack_q    <= clr_ack_d;
            ts_q         <= ts_q + TS_W'(1);
            qual_prev_q  <= qual_c;
            sticky_q     <= sticky_d;
            first_code_q <= first_code_d;
            first_ts_q   <= first_ts_d;
            irq_q        <= irq_d;
            cnt_out_q    <= cnt_out_d;
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                q_cnt_q[i]  <= q_cnt_d[i];
                ev_cnt_q[i] <= ev_cnt_d[i];
            end
        end
    end

    assign clr_ack    = clr_ack_q;
    assign cnt_out    = cnt_out_q;
    assign sticky     = sticky_q;
    assign first_code = first_code_q;
    assign first_ts   = first_ts_q;
    assign crash      = |sticky_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_fault_status_monitor.sv
// Testbench for fault_status_monitor: cycle reference model feeds an expectation
// queue, directed checks cover qualification, priority, clear, mask and saturation.
module tb_fault_status_monitor;

    localparam int unsigned NUM_SRC  = 4;
    localparam int unsigned CODE_W   = 3;
    localparam int unsigned QUAL_CYC = 4;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned TS_W     = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic [NUM_SRC-1:0]  fault_in;
    logic [NUM_SRC-1:0]  fault_mask;
    logic                clr_req;
    logic                clr_ack;
    logic [CODE_W-1:0]   cnt_sel;
    logic [CNT_W-1:0]    cnt_out;
    logic [NUM_SRC-1:0]  sticky;
    logic [CODE_W-1:0]   crash_code;
    logic [CODE_W-1:0]   first_code;
    logic [TS_W-1:0]     first_ts;
    logic                crash;
    logic                irq;

    fault_status_monitor #(
        .NUM_SRC(NUM_SRC), .CODE_W(CODE_W), .QUAL_CYC(QUAL_CYC),
        .CNT_W(CNT_W), .TS_W(TS_W)
    ) dut (
        .clk(clk), .rst(rst), .fault_in(fault_in), .fault_mask(fault_mask),
        .clr_req(clr_req), .clr_ack(clr_ack), .cnt_sel(cnt_sel), .cnt_out(cnt_out),
        .sticky(sticky), .crash_code(crash_code), .first_code(first_code),
        .first_ts(first_ts), .crash(crash), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sticky;
        int crash_code;
        int crash;
        int first_code;
        int first_ts;
        int irq;
        int clr_ack;
        int cnt_out;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Reference model state
    int m_ts;
    int m_run [NUM_SRC];
    int m_cnt [NUM_SRC];
    int m_sticky;
    int m_fc;
    int m_fts;
    int m_st;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ts = 0; m_sticky = 0; m_fc = 0; m_fts = 0; m_st = 0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            m_run[i] = 0;
            m_cnt[i] = 0;
        end
        sb_q.delete();
    endtask

    // Advance the model by one clock using the inputs currently driven
    task automatic model_eval();
        exp_t e;
        int   ev, base_st, low, nxt, code;
        bit   clr;
        clr = (m_st == 1);
        ev  = 0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (m_run[i] == int'(QUAL_CYC)) ev |= (1 << i);
        end
        e.cnt_out = (int'(cnt_sel) < int'(NUM_SRC)) ? m_cnt[cnt_sel] : 0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (fault_in[i] && !fault_mask[i])
                m_run[i] = (m_run[i] > int'(QUAL_CYC)) ? m_run[i] : m_run[i] + 1;
            else
                m_run[i] = 0;
        end
        base_st = clr ? 0 : m_sticky;
        e.irq   = ((ev & ~base_st) != 0) ? 1 : 0;
        m_sticky = base_st | ev;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (clr) m_cnt[i] = 0;
            if (((ev >> i) & 1) == 1 && m_cnt[i] < 255) m_cnt[i]++;
        end
        if (clr) begin
            m_fc  = 0;
            m_fts = 0;
        end
        if (m_fc == 0 && ev != 0) begin
            low = 0;
            while (((ev >> low) & 1) == 0) low++;
            m_fc  = low + 1;
            m_fts = m_ts;
        end
        case (m_st)
            0:       nxt = clr_req ? 1 : 0;
            1:       nxt = 2;
            default: nxt = clr_req ? 2 : 0;
        endcase
        m_st = nxt;
        m_ts = (m_ts + 1) % 65536;
        code = 0;
        for (int i = 0; i < int'(NUM_SRC) && code == 0; i++) begin
            if (((m_sticky >> i) & 1) == 1) code = i + 1;
        end
        e.sticky     = m_sticky;
        e.crash_code = code;
        e.crash      = (m_sticky != 0) ? 1 : 0;
        e.first_code = m_fc;
        e.first_ts   = m_fts;
        e.clr_ack    = (m_st == 2) ? 1 : 0;
        sb_q.push_back(e);
    endtask

    // One clock: push expectation, clock the DUT, pop and compare
    task automatic step();
        exp_t e;
        model_eval();
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL sb_empty: no expectation queued at %0t", $time);
        end else begin
            e = sb_q.pop_front();
            check("sticky",     int'(sticky),     e.sticky);
            check("crash_code", int'(crash_code), e.crash_code);
            check("crash",      int'(crash),      e.crash);
            check("first_code", int'(first_code), e.first_code);
            check("first_ts",   int'(first_ts),   e.first_ts);
            check("irq",        int'(irq),        e.irq);
            check("clr_ack",    int'(clr_ack),    e.clr_ack);
            check("cnt_out",    int'(cnt_out),    e.cnt_out);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sticky"},     int'(sticky),     0);
        check({tag, "_crash_code"}, int'(crash_code), 0);
        check({tag, "_crash"},      int'(crash),      0);
        check({tag, "_first_code"}, int'(first_code), 0);
        check({tag, "_first_ts"},   int'(first_ts),   0);
        check({tag, "_irq"},        int'(irq),        0);
        check({tag, "_clr_ack"},    int'(clr_ack),    0);
        check({tag, "_cnt_out"},    int'(cnt_out),    0);
    endtask

    // Asynchronous reset mid-cycle; called just after an active edge
    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        clr_req = 1'b0;
        #1 check_all_zero(tag);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic do_clear();
        clr_req = 1'b1;
        step();
        check("clr_ack_early", int'(clr_ack), 0);
        step();
        check("clr_ack_2cyc", int'(clr_ack), 1);
        check("clr_sticky", int'(sticky), 0);
        check("clr_first", int'(first_code), 0);
        repeat (3) step();
        check("clr_ack_held", int'(clr_ack), 1);
        clr_req = 1'b0;
        step();
        check("clr_ack_drop", int'(clr_ack), 0);
    endtask

    int irq_cnt;

    initial begin
        rst = 1'b1;
        fault_in = '0; fault_mask = '0; clr_req = 1'b0; cnt_sel = '0;
        @(posedge clk);
        @(posedge clk);
        #1 check_all_zero("rst_init");
        rst = 1'b0;
        model_reset();

        // Priority and first-fault capture with timestamp
        while (m_ts != 96) step();
        fault_in = 4'b0100;
        while (m_ts != 116) step();
        fault_in = 4'b0101;
        repeat (6) step();
        check("prio_code", int'(crash_code), 1);
        check("prio_first", int'(first_code), 3);
        check("prio_ts", int'(first_ts), 100);
        check("prio_sticky", int'(sticky), 5);
        fault_in = '0;
        step();

        // Clear handshake wipes counters
        do_clear();
        cnt_sel = '0;
        step();
        check("clr_cnt0", int'(cnt_out), 0);

        // Simultaneous sources 1 and 3
        fault_in = 4'b1010;
        repeat (6) step();
        check("simul_first", int'(first_code), 2);
        check("simul_code", int'(crash_code), 2);
        fault_in = '0;
        repeat (2) step();

        // Event landing in the clear cycle survives the wipe
        fault_in = 4'b0001;
        repeat (3) step();
        clr_req = 1'b1;
        step();
        step();
        check("evclr_sticky", int'(sticky), 1);
        check("evclr_first", int'(first_code), 1);
        check("evclr_irq", int'(irq), 1);
        step();
        check("evclr_ack", int'(clr_ack), 1);
        clr_req = 1'b0;
        fault_in = '0;
        cnt_sel = '0;
        repeat (2) step();
        check("evclr_cnt", int'(cnt_out), 1);

        // Reset while acknowledging a clear
        clr_req = 1'b1;
        repeat (3) step();
        check("ack_before_rst", int'(clr_ack), 1);
        async_reset("rst_mid");

        // Qualification threshold
        fault_in = 4'b0010;
        repeat (3) step();
        fault_in = '0;
        repeat (3) step();
        check("short_sticky", int'(sticky), 0);
        fault_in = 4'b0010;
        repeat (4) step();
        check("qual_pre", int'(sticky), 0);
        step();
        check("qual_sticky", int'(sticky), 2);
        check("qual_code", int'(crash_code), 2);
        check("qual_irq", int'(irq), 1);
        check("qual_first", int'(first_code), 2);
        step();
        check("qual_irq_off", int'(irq), 0);
        fault_in = '0;
        step();

        // Mask blocks new events but keeps history
        fault_in = 4'b0001;
        repeat (6) step();
        fault_in = '0;
        step();
        fault_mask = 4'b0001;
        fault_in = 4'b0001;
        repeat (50) step();
        check("mask_sticky", int'(sticky[0]), 1);
        cnt_sel = '0;
        repeat (2) step();
        check("mask_cnt", int'(cnt_out), 1);
        fault_in = '0;
        step();
        fault_mask = '0;
        step();

        // Saturating counter, irq only on first pulse
        do_clear();
        cnt_sel = '0;
        irq_cnt = 0;
        repeat (300) begin
            fault_in = 4'b0001;
            repeat (5) begin
                step();
                if (irq) irq_cnt++;
            end
            fault_in = '0;
            step();
            if (irq) irq_cnt++;
        end
        step();
        check("sat_cnt", int'(cnt_out), 255);
        check("sat_irq", irq_cnt, 1);
        cnt_sel = 3'd5;
        repeat (2) step();
        check("sel_oob", int'(cnt_out), 0);

        // Random traffic against the model
        repeat (600) begin
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                if ($urandom_range(0, 5) == 0) fault_in[i] = ~fault_in[i];
                if ($urandom_range(0, 40) == 0) fault_mask[i] = ~fault_mask[i];
            end
            if ($urandom_range(0, 15) == 0) clr_req = ~clr_req;
            cnt_sel = CODE_W'($urandom_range(0, 7));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
